// File: rtl/mdio_rx_param_pkg.sv
// Shared encodings and widths for the parametrised MDIO Clause 22 receiver.
package mdio_rx_param_pkg;

    typedef enum logic [2:0] {
        S_PRE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_WDATA,
        S_RDATA
    } state_t;

    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] ST_C22 = 2'b01;
    localparam logic [1:0] TA_WR  = 2'b10;

    localparam int unsigned PHYAD_W   = 5;
    localparam int unsigned PRE_CNT_W = 6;

endpackage

// File: rtl/mdio_rx_param_piso.sv
// Parallel-load, MSB-first shift register that drives the serial read data pin.
module mdio_rx_param_piso #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              sout
);

    logic [DATA_W-1:0] sh;

    // Load presents a 0 (turnaround bit); each shift presents the next MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            sout <= 1'b0;
        end else if (clr) begin
            sh   <= '0;
            sout <= 1'b0;
        end else if (load) begin
            sh   <= din;
            sout <= 1'b0;
        end else if (shift) begin
            sout <= sh[DATA_W-1];
            sh   <= {sh[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdio_rx_param.sv
// MDIO Clause 22 receiver: preamble filter, frame deserialiser, PHY address match, read shifter.
// Optional MDIO_TA_CHECK_EN: flags bad ST/OP/write-TA on mdio_err and rejects the frame.
module mdio_rx_param
    import mdio_rx_param_pkg::*;
#(
    parameter int unsigned          DATA_W   = 16,
    parameter int unsigned          ADDR_W   = 5,
    parameter logic [PHYAD_W-1:0]   PHY_ADDR = 5'h01,
    parameter int unsigned          PRE_LEN  = 32
) (
    input  logic              mdc,
    input  logic              reset,
    input  logic              mdio_out,
    input  logic              mdio_oe,
    input  logic [DATA_W-1:0] rd_data,
    output logic              mdio_in,
    output logic              mdio_in_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_stb,
    output logic              mdio_done,
    output logic              mdio_err
);

`ifdef MDIO_TA_CHECK_EN
    localparam logic TA_CHECK = 1'b1;
`else
    localparam logic TA_CHECK = 1'b0;
`endif

    localparam int unsigned BIT_CNT_W = $clog2(DATA_W + ADDR_W + PHYAD_W);
    localparam logic [BIT_CNT_W-1:0] ONE       = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] PHY_LAST  = BIT_CNT_W'(PHYAD_W - 1);
    localparam logic [BIT_CNT_W-1:0] REG_LAST  = BIT_CNT_W'(ADDR_W - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_W - 1);
    localparam logic [PRE_CNT_W-1:0] PRE_MAX   = PRE_CNT_W'(PRE_LEN);
    localparam logic [PRE_CNT_W-1:0] PRE_ONE   = PRE_CNT_W'(1);

    state_t                 state;
    logic [PRE_CNT_W-1:0]   pre_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   op_hi;
    logic                   ta_hi;
    logic                   is_rd;
    logic                   match;
    logic                   err_seen;
    logic [PHYAD_W-1:0]     phy_sh;
    logic [ADDR_W-1:0]      reg_sh;
    logic [DATA_W-1:0]      dat_sh;
    logic [ADDR_W-1:0]      reg_nxt;
    logic [DATA_W-1:0]      dat_nxt;
    logic                   rd_active;
    logic                   piso_load;
    logic                   piso_shift;
    logic                   piso_clr;

    assign reg_nxt   = {reg_sh[ADDR_W-2:0], mdio_out};
    assign dat_nxt   = {dat_sh[DATA_W-2:0], mdio_out};
    assign rd_active = is_rd && match;

    // Read shifter: load on first TA cycle, then one shift per cycle up to the last data bit.
    assign piso_load  = (state == S_TA) && (bit_cnt == '0) && rd_active;
    assign piso_shift = rd_active && (((state == S_TA) && (bit_cnt == ONE)) ||
                                      ((state == S_RDATA) && (bit_cnt != DATA_LAST)));
    assign piso_clr   = !((state == S_TA) || (state == S_RDATA)) ||
                        ((state == S_RDATA) && (bit_cnt == DATA_LAST));

    mdio_rx_param_piso #(.DATA_W(DATA_W)) u_piso (
        .clk   (mdc),
        .rst_n (reset),
        .clr   (piso_clr),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (rd_data),
        .sout  (mdio_in)
    );

    always_ff @(posedge mdc or negedge reset) begin
        if (!reset) begin
            state      <= S_PRE;
            pre_cnt    <= '0;
            bit_cnt    <= '0;
            op_hi      <= 1'b0;
            ta_hi      <= 1'b0;
            is_rd      <= 1'b0;
            match      <= 1'b0;
            err_seen   <= 1'b0;
            phy_sh     <= '0;
            reg_sh     <= '0;
            dat_sh     <= '0;
            addr       <= '0;
            wr_data    <= '0;
            wr_stb     <= 1'b0;
            mdio_done  <= 1'b0;
            mdio_err   <= 1'b0;
            mdio_in_en <= 1'b0;
        end else begin
            wr_stb    <= 1'b0;
            mdio_done <= 1'b0;
            mdio_err  <= 1'b0;
            case (state)
                // Count consecutive driven 1s; a 0 after a full preamble is the first ST bit.
                S_PRE: begin
                    if (mdio_oe && mdio_out) begin
                        if (pre_cnt < PRE_MAX) pre_cnt <= pre_cnt + PRE_ONE;
                    end else if (mdio_oe && (pre_cnt >= PRE_MAX)) begin
                        state   <= S_ST;
                        pre_cnt <= '0;
                    end else begin
                        pre_cnt <= '0;
                    end
                end
                S_ST: begin
                    if (!mdio_oe) begin
                        state <= S_PRE;
                    end else if ({1'b0, mdio_out} == ST_C22) begin
                        state   <= S_OP;
                        bit_cnt <= '0;
                    end else begin
                        state    <= S_PRE;
                        mdio_err <= TA_CHECK;
                    end
                end
                S_OP: begin
                    if (!mdio_oe) begin
                        state <= S_PRE;
                    end else if (bit_cnt == '0) begin
                        op_hi   <= mdio_out;
                        bit_cnt <= ONE;
                    end else begin
                        bit_cnt <= '0;
                        if ({op_hi, mdio_out} == OP_WR) begin
                            is_rd <= 1'b0;
                            state <= S_PHYAD;
                        end else if ({op_hi, mdio_out} == OP_RD) begin
                            is_rd <= 1'b1;
                            state <= S_PHYAD;
                        end else begin
                            state    <= S_PRE;
                            mdio_err <= TA_CHECK;
                        end
                    end
                end
                S_PHYAD: begin
                    if (!mdio_oe) begin
                        state <= S_PRE;
                    end else begin
                        phy_sh <= {phy_sh[PHYAD_W-2:0], mdio_out};
                        if (bit_cnt == PHY_LAST) begin
                            state   <= S_REGAD;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + ONE;
                        end
                    end
                end
                S_REGAD: begin
                    if (!mdio_oe) begin
                        state <= S_PRE;
                    end else begin
                        reg_sh <= reg_nxt;
                        if (bit_cnt == REG_LAST) begin
                            match    <= (phy_sh == PHY_ADDR);
                            err_seen <= 1'b0;
                            if (phy_sh == PHY_ADDR) addr <= reg_nxt;
                            state    <= S_TA;
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + ONE;
                        end
                    end
                end
                // Controller releases the line during a read TA, so OE only aborts writes here.
                S_TA: begin
                    if (!is_rd && !mdio_oe) begin
                        state <= S_PRE;
                    end else if (bit_cnt == '0) begin
                        ta_hi   <= mdio_out;
                        bit_cnt <= ONE;
                        if (rd_active) mdio_in_en <= 1'b1;
                    end else begin
                        bit_cnt <= '0;
                        if (is_rd) begin
                            state <= S_RDATA;
                        end else if (TA_CHECK && ({ta_hi, mdio_out} != TA_WR)) begin
                            state    <= S_PRE;
                            mdio_err <= match;
                        end else begin
                            state <= S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (!mdio_oe) begin
                        state <= S_PRE;
                    end else begin
                        dat_sh <= dat_nxt;
                        if (bit_cnt == DATA_LAST) begin
                            state   <= S_PRE;
                            bit_cnt <= '0;
                            if (match) begin
                                wr_data   <= dat_nxt;
                                wr_stb    <= 1'b1;
                                mdio_done <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + ONE;
                        end
                    end
                end
                // Contention on the line is reported once per read; the read still completes.
                S_RDATA: begin
                    if (mdio_oe && match && !err_seen) begin
                        mdio_err <= 1'b1;
                        err_seen <= 1'b1;
                    end
                    if (bit_cnt == DATA_LAST) begin
                        state      <= S_PRE;
                        bit_cnt    <= '0;
                        mdio_in_en <= 1'b0;
                        mdio_done  <= match;
                    end else begin
                        bit_cnt <= bit_cnt + ONE;
                    end
                end
                default: state <= S_PRE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_rx_param.sv
// Bench for mdio_rx_param: frame table with scoreboard, plus abort/reset/no-preamble sequences.
module tb_mdio_rx_param;

`ifdef MDIO_TA_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        mdc = 1'b0;
    logic        reset;
    logic        mdio_out;
    logic        oe_a;
    logic        oe_b;
    logic [15:0] rd_data;

    logic        mdio_in, mdio_in_en, wr_stb, mdio_done, mdio_err;
    logic [4:0]  addr;
    logic [15:0] wr_data;
    logic        mdio_in_b, mdio_in_en_b, wr_stb_b, mdio_done_b, mdio_err_b;
    logic [4:0]  addr_b;
    logic [15:0] wr_data_b;

    always #5 mdc = ~mdc;

    mdio_rx_param #(.DATA_W(16), .ADDR_W(5), .PHY_ADDR(5'h01), .PRE_LEN(32)) dut (
        .mdc(mdc), .reset(reset), .mdio_out(mdio_out), .mdio_oe(oe_a), .rd_data(rd_data),
        .mdio_in(mdio_in), .mdio_in_en(mdio_in_en), .addr(addr), .wr_data(wr_data),
        .wr_stb(wr_stb), .mdio_done(mdio_done), .mdio_err(mdio_err)
    );

    mdio_rx_param #(.DATA_W(16), .ADDR_W(5), .PHY_ADDR(5'h01), .PRE_LEN(0)) dut_b (
        .mdc(mdc), .reset(reset), .mdio_out(mdio_out), .mdio_oe(oe_b), .rd_data(rd_data),
        .mdio_in(mdio_in_b), .mdio_in_en(mdio_in_en_b), .addr(addr_b), .wr_data(wr_data_b),
        .wr_stb(wr_stb_b), .mdio_done(mdio_done_b), .mdio_err(mdio_err_b)
    );

    typedef struct packed { logic [4:0] a; logic [15:0] d; } exp_t;
    typedef struct {
        int          pre;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [1:0]  ta;
        logic [15:0] data;
        logic        hold;
        logic        acc;
        int          errs;
    } vec_t;

    exp_t        exp_wr[$];
    exp_t        exp_b[$];
    logic [15:0] exp_rd[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          err_cnt = 0;
    int          en_cnt = 0;
    logic [16:0] cap = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard for the PRE_LEN=32 instance.
    always @(negedge mdc) begin
        if (reset) begin
            exp_t        e;
            logic [15:0] r;
            if (mdio_err) err_cnt++;
            if (mdio_in_en) begin
                cap = {cap[15:0], mdio_in};
                en_cnt++;
            end
            if (wr_stb) begin
                check("wr_stb_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(addr), 32'(e.a));
                    check("wr_data", 32'(wr_data), 32'(e.d));
                    check("wr_done", 32'(mdio_done), 32'd1);
                end
            end else if (mdio_done) begin
                check("rd_done_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) begin
                    r = exp_rd.pop_front();
                    check("rd_serial", 32'(cap), 32'({1'b0, r}));
                    check("rd_en_cycles", 32'(en_cnt), 32'd17);
                end
                en_cnt = 0;
            end
        end
    end

    // Scoreboard for the PRE_LEN=0 instance.
    always @(negedge mdc) begin
        if (reset && wr_stb_b) begin
            exp_t e;
            check("b_wr_stb_expected", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) begin
                e = exp_b.pop_front();
                check("b_wr_addr", 32'(addr_b), 32'(e.a));
                check("b_wr_data", 32'(wr_data_b), 32'(e.d));
            end
        end
    end

    task automatic drive(input logic b, input logic oe, input bit sel_b);
        @(negedge mdc);
        mdio_out = b;
        oe_a = sel_b ? 1'b0 : oe;
        oe_b = sel_b ? oe : 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input logic oe, input bit sel_b);
        for (int i = n - 1; i >= 0; i--) drive(bits[i], oe, sel_b);
    endtask

    task automatic send_frame(input bit sel_b, input int pre, input logic [1:0] op,
                              input logic [4:0] phy, input logic [4:0] regad, input logic [1:0] ta,
                              input logic [15:0] data, input logic hold, input int gap);
        rd_data = data;
        for (int i = 0; i < pre; i++) drive(1'b1, 1'b1, sel_b);
        send_bits(32'({2'b01, op, phy, regad}), 14, 1'b1, sel_b);
        if (op == 2'b10) begin
            for (int i = 0; i < 18; i++) drive(1'b0, hold, sel_b);
        end else begin
            send_bits(32'({ta, data}), 18, 1'b1, sel_b);
        end
        for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, sel_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        v[10];
        logic [4:0]  m_addr = '0;
        logic [15:0] m_wr = '0;
        int          e0;
        logic        upd;

        v[0] = '{32, 2'b01, 5'h01, 5'h02, 2'b10, 16'hA5F0, 1'b0, 1'b1, 0};
        v[1] = '{32, 2'b10, 5'h01, 5'h03, 2'b00, 16'h8FF1, 1'b0, 1'b1, 0};
        v[2] = '{32, 2'b01, 5'h03, 5'h06, 2'b10, 16'h1234, 1'b0, 1'b0, 0};
        v[3] = '{31, 2'b01, 5'h01, 5'h07, 2'b10, 16'h5555, 1'b0, 1'b0, 0};
        v[4] = '{40, 2'b01, 5'h01, 5'h1F, 2'b10, 16'hFFFF, 1'b0, 1'b1, 0};
        v[5] = '{32, 2'b10, 5'h01, 5'h00, 2'b00, 16'h0001, 1'b0, 1'b1, 0};
        v[6] = '{32, 2'b01, 5'h01, 5'h05, 2'b11, 16'h0F0F, 1'b0, !CHK, CHK ? 1 : 0};
        v[7] = '{32, 2'b10, 5'h02, 5'h09, 2'b00, 16'hC3C3, 1'b0, 1'b0, 0};
        v[8] = '{32, 2'b11, 5'h01, 5'h0C, 2'b10, 16'h7777, 1'b0, 1'b0, CHK ? 1 : 0};
        v[9] = '{32, 2'b10, 5'h01, 5'h14, 2'b00, 16'h6B2D, 1'b1, 1'b1, 1};

        reset = 1'b0; oe_a = 1'b0; oe_b = 1'b0; mdio_out = 1'b0; rd_data = '0;
        repeat (3) @(negedge mdc);
        check("reset_ctl", 32'({mdio_in, mdio_in_en, wr_stb, mdio_done, mdio_err}), 32'd0);
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        reset = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            e0  = err_cnt;
            upd = (v[i].pre >= 32) && (v[i].op == 2'b01 || v[i].op == 2'b10) && (v[i].phy == 5'h01);
            if (upd) m_addr = v[i].regad;
            if (v[i].acc) begin
                if (v[i].op == 2'b10) exp_rd.push_back(v[i].data);
                else begin
                    exp_wr.push_back('{a: v[i].regad, d: v[i].data});
                    m_wr = v[i].data;
                end
            end
            send_frame(1'b0, v[i].pre, v[i].op, v[i].phy, v[i].regad, v[i].ta, v[i].data, v[i].hold, 3);
            check($sformatf("v%0d_addr", i), 32'(addr), 32'(m_addr));
            check($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(m_wr));
            check($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(v[i].errs));
            check($sformatf("v%0d_pending", i), 32'(exp_wr.size() + exp_rd.size()), 32'd0);
        end

        // OE dropped after 8 data bits: no strobe, ADDR keeps the captured REGAD.
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b1, 1'b0);
        send_bits(32'({2'b01, 2'b01, 5'h01, 5'h0A}), 14, 1'b1, 1'b0);
        send_bits(32'({2'b10, 8'hC3}), 10, 1'b1, 1'b0);
        repeat (12) drive(1'b1, 1'b0, 1'b0);
        m_addr = 5'h0A;
        check("abort_addr", 32'(addr), 32'(m_addr));
        check("abort_wr_data", 32'(wr_data), 32'(m_wr));
        check("abort_ctl", 32'({mdio_in_en, wr_stb, mdio_done}), 32'd0);
        exp_wr.push_back('{a: 5'h0D, d: 16'h3C5A});
        send_frame(1'b0, 32, 2'b01, 5'h01, 5'h0D, 2'b10, 16'h3C5A, 1'b0, 3);
        m_addr = 5'h0D; m_wr = 16'h3C5A;
        check("post_abort_addr", 32'(addr), 32'(m_addr));
        check("post_abort_pending", 32'(exp_wr.size()), 32'd0);

        // Asynchronous reset mid-write: outputs clear at once, write is never strobed.
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b1, 1'b0);
        send_bits(32'({2'b01, 2'b01, 5'h01, 5'h0B}), 14, 1'b1, 1'b0);
        send_bits(32'({2'b10, 8'h99}), 10, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_ctl", 32'({mdio_in, mdio_in_en, wr_stb, mdio_done, mdio_err}), 32'd0);
        check("rst_mid_addr", 32'(addr), 32'd0);
        check("rst_mid_wr_data", 32'(wr_data), 32'd0);
        #1 reset = 1'b1;
        send_bits(32'(8'h66), 8, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        check("rst_after_addr", 32'(addr), 32'd0);
        exp_wr.push_back('{a: 5'h0E, d: 16'hE1D2});
        send_frame(1'b0, 32, 2'b01, 5'h01, 5'h0E, 2'b10, 16'hE1D2, 1'b0, 3);
        check("post_rst_addr", 32'(addr), 32'h0E);
        check("post_rst_pending", 32'(exp_wr.size()), 32'd0);

        // PRE_LEN=0 instance: no preamble, then two frames back to back.
        exp_b.push_back('{a: 5'h11, d: 16'hBEEF});
        send_frame(1'b1, 0, 2'b01, 5'h01, 5'h11, 2'b10, 16'hBEEF, 1'b0, 3);
        check("b_single_pending", 32'(exp_b.size()), 32'd0);
        exp_b.push_back('{a: 5'h12, d: 16'h1357});
        exp_b.push_back('{a: 5'h13, d: 16'h2468});
        send_frame(1'b1, 0, 2'b01, 5'h01, 5'h12, 2'b10, 16'h1357, 1'b0, 0);
        send_frame(1'b1, 0, 2'b01, 5'h01, 5'h13, 2'b10, 16'h2468, 1'b0, 3);
        check("b_b2b_pending", 32'(exp_b.size()), 32'd0);
        check("b_addr", 32'(addr_b), 32'h13);
        check("a_ignored_b_frames", 32'(addr), 32'h0E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
